// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit controller with architectural HI/LO.
// Multiplication uses radix-2 shift-add. Division uses restoring
// shift-subtract. Both run on operand magnitudes, and the sign is fixed up
// in a single FIX cycle.
// Handshake: start is accepted only in IDLE. busy covers RUN and FIX.
// done pulses for one cycle after HI/LO are written. flush cancels the
// operation in flight and takes priority over start.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic               div_op;
    logic               neg_q;     // quotient/product must be negated
    logic               neg_r;     // remainder takes the dividend's sign
    logic               b_zero;
    logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi;    // partial product high / remainder
    logic [WIDTH-1:0]   acc_lo;    // multiplier / dividend-quotient

    logic               op_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               last;
    logic               accept;

    assign busy      = (state != IDLE);
    assign stall     = rd_req & busy;
    assign fsm_state = state;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign accept    = start & ~flush;

    // Operand magnitudes and one datapath step for each algorithm
    always_comb begin
        op_signed = ~op[0];
        a_abs     = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_abs     = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand};
        div_ge    = (div_shift >= {1'b0, mcand});
        prod_raw  = {acc_hi, acc_lo};
        prod_fix  = neg_q ? (~prod_raw + (2*WIDTH)'(1)) : prod_raw;
        quo_fix   = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_fix   = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !op[2]) state_next = RUN;
            RUN: begin
                if (flush)     state_next = IDLE;
                else if (last) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Datapath, HI/LO, dz and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            div_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            dz     <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                cnt    <= '0;
                                div_op <= op[1];
                                neg_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r  <= op_signed & a[WIDTH-1];
                                b_zero <= (b == '0);
                                acc_hi <= '0;
                                acc_lo <= op[1] ? a_abs : b_abs;
                                mcand  <= op[1] ? b_abs : a_abs;
                            end
                            3'b100:  hi <= a;
                            3'b101:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt <= cnt + CW'(1);
                        if (div_op) begin
                            acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (div_op) begin
                            // Divide by zero: the restoring loop leaves |a| in
                            // the remainder, so rem_fix already equals a.
                            lo <= b_zero ? '1 : quo_fix;
                            hi <= rem_fix;
                            dz <= b_zero;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with WIDTH=32: a vector table of full operations
// followed by hand-written sequences for mthi/mtlo, flush, reset and start-hold.
module tb_mdu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         flush;
    logic         rd_req;
    logic         busy, done, stall, dz;
    logic [W-1:0] hi, lo;
    logic [1:0]   fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .rd_req(rd_req), .busy(busy), .done(done),
        .stall(stall), .hi(hi), .lo(lo), .dz(dz), .fsm_state(fsm_state)
    );

    // Clock and a hard time limit
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one iterative op, then wait (bounded) for done
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int edges, output int busy_n, output int stall_n);
        start = 1'b1; op = o; a = va; b = vb;
        tick();
        start = 1'b0;
        edges = 0; busy_n = 0; stall_n = 0;
        while (!done && edges < 100) begin
            if (busy)  busy_n++;
            if (stall) stall_n++;
            tick();
            edges++;
        end
    endtask

    int edges, busy_n, stall_n, done_n;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        flush = 1'b0; rd_req = 1'b0;

        vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{3'b011, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1};
        vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{3'b010, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{3'b011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[9]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{3'b001, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[11] = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

        // Reset state
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(dz), 64'd0);
        rst_n = 1'b1;

        // Vector table; the first start lands on the first edge after release
        rd_req = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, busy_n, stall_n);
            check($sformatf("v%0d_latency", i), 64'(edges), 64'd33);
            check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'd33);
            check($sformatf("v%0d_stall_cycles", i), 64'(stall_n), 64'd33);
            check($sformatf("v%0d_stall_on_done", i), 64'(stall), 64'd0);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
            tick();
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
        end
        rd_req = 1'b0;

        // mthi / mtlo: single cycle, no busy, no done
        start = 1'b1; op = 3'b100; a = 32'hAABBCCDD;
        tick();
        check("mthi_hi", 64'(hi), 64'hAABBCCDD);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        op = 3'b101; a = 32'h12345678;
        tick();
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h12345678);
        check("mtlo_hi_kept", 64'(hi), 64'hAABBCCDD);
        check("mtlo_done", 64'(done), 64'd0);

        // Flush a mult at RUN cycle 10
        rd_req = 1'b1;
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("flush_pre_stall", 64'(stall), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_stall", 64'(stall), 64'd0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_n++;
            tick();
        end
        check("flush_no_done", 64'(done_n), 64'd0);
        check("flush_lo_kept", 64'(lo), 64'h12345678);
        check("flush_hi_kept", 64'(hi), 64'hAABBCCDD);
        rd_req = 1'b0;

        // Flush beats start in IDLE, for both mthi and an iterative op
        flush = 1'b1; start = 1'b1; op = 3'b100; a = 32'h0;
        tick();
        check("flush_start_mthi", 64'(hi), 64'hAABBCCDD);
        op = 3'b000;
        tick();
        flush = 1'b0; start = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);

        // Reserved op alone does nothing
        start = 1'b1; op = 3'b111; a = 32'h1; b = 32'h1;
        tick();
        start = 1'b0;
        check("reserved_state", 64'(fsm_state), 64'd0);
        check("reserved_busy", 64'(busy), 64'd0);

        // Reset pulse in the middle of a div
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        tick();
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_n++;
            tick();
        end
        check("midrst_no_done", 64'(done_n), 64'd0);
        run_op(3'b011, 32'd100, 32'd7, edges, busy_n, stall_n);
        check("postrst_latency", 64'(edges), 64'd33);
        check("postrst_lo", 64'(lo), 64'd14);
        check("postrst_hi", 64'(hi), 64'd2);
        tick();

        // start held high: multu issued, then reserved op held through the rest
        start = 1'b1; op = 3'b001; a = 32'd6; b = 32'd7;
        tick();
        op = 3'b110; a = 32'hDEAD; b = 32'hBEEF;
        done_n = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) done_n++;
            tick();
        end
        start = 1'b0;
        check("hold_done_count", 64'(done_n), 64'd1);
        check("hold_busy", 64'(busy), 64'd0);
        check("hold_hi", 64'(hi), 64'd0);
        check("hold_lo", 64'(lo), 64'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
